game_scheduler: RTL

Round scheduler for the reaction game; it sits between the login/access controller and the two player load registers. It runs the round countdown and returns the `timeout` that ends PLAY. It also shares the single load-strobe path between player 1 and player R using round-robin arbitration with a per-round load cap. It is armed by `reconf`, runs while `enable` is high, and never touches the password datapath.

---
 rtl/game_pkg.sv | 17 +
 rtl/round_timer.sv | 27 ++
 rtl/game_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the reaction-game round scheduler.
// Holds FSM encodings, default round/cap sizes and datapath widths.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARM    = 2'b01,
        ST_RUN    = 2'b10,
        ST_EXPIRE = 2'b11
    } state_t;

    localparam int unsigned DEF_ROUND_TICKS = 60;
    localparam int unsigned DEF_LOAD_LIMIT  = 4;
    localparam int unsigned TIME_W          = 8;
    localparam int unsigned CNT_W           = 3;

endpackage

// File: rtl/round_timer.sv
// Round countdown: loadable down-counter, decrements on dec, never wraps below zero.
// Value is registered, updates one edge after load/dec; zero flag decodes the register.
module round_timer
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              dec,
    output logic [TIME_W-1:0] value,
    output logic              zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/game_scheduler.sv
// Round scheduler: countdown to timeout plus round-robin sharing of the load strobe with a per-round cap.
// Grants appear one cycle after the sampled request; a losing request waits at most one extra cycle.
module game_scheduler
    import game_pkg::*;
#(
    parameter int unsigned ROUND_TICKS = DEF_ROUND_TICKS,
    parameter int unsigned LOAD_LIMIT  = DEF_LOAD_LIMIT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              reconf,
    input  logic              tick,
    input  logic              req_1,
    input  logic              req_R,
    output logic              grant_1,
    output logic              grant_R,
    output logic              timeout,
    output logic [TIME_W-1:0] time_left,
    output logic [CNT_W-1:0]  count_1,
    output logic [CNT_W-1:0]  count_R,
    output logic [1:0]        state
);

    localparam logic [TIME_W-1:0] ROUND_LOAD = TIME_W'(ROUND_TICKS);
    localparam logic [CNT_W-1:0]  LIMIT      = CNT_W'(LOAD_LIMIT);

    state_t st;
    logic   pend_1, pend_R;
    logic   last_r;          // 1: player R won the last contested grant
    logic   timer_zero;
    logic   running, final_tick, arb_en;
    logic   cand_1, cand_R, both, pick_1, pick_R, g_1, g_R;
    logic   timer_load, timer_dec;

    assign running    = (st == ST_RUN) && enable;
    assign final_tick = tick && ((time_left == TIME_W'(1)) || timer_zero);
    assign arb_en     = running && !final_tick;

    assign cand_1 = (pend_1 || req_1) && (count_1 < LIMIT);
    assign cand_R = (pend_R || req_R) && (count_R < LIMIT);
    assign both   = cand_1 && cand_R;
    assign pick_1 = cand_1 && (!cand_R || last_r);
    assign pick_R = cand_R && (!cand_1 || !last_r);
    assign g_1    = arb_en && pick_1;
    assign g_R    = arb_en && pick_R;

    assign timer_load = reconf && ((st == ST_IDLE) || (st == ST_ARM));
    assign timer_dec  = running && tick;

    round_timer u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (timer_load),
        .load_val (ROUND_LOAD),
        .dec      (timer_dec),
        .value    (time_left),
        .zero     (timer_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            st      <= ST_IDLE;
            grant_1 <= 1'b0;
            grant_R <= 1'b0;
            timeout <= 1'b0;
            count_1 <= '0;
            count_R <= '0;
            pend_1  <= 1'b0;
            pend_R  <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            grant_1 <= g_1;
            grant_R <= g_R;
            case (st)
                ST_IDLE, ST_ARM: begin
                    timeout <= 1'b0;
                    if (reconf) begin
                        count_1 <= '0;
                        count_R <= '0;
                        pend_1  <= 1'b0;
                        pend_R  <= 1'b0;
                        st      <= ST_ARM;
                    end else if ((st == ST_ARM) && enable) begin
                        st <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        pend_1 <= 1'b0;
                        pend_R <= 1'b0;
                        st     <= ST_IDLE;
                    end else if (final_tick) begin
                        pend_1  <= 1'b0;
                        pend_R  <= 1'b0;
                        timeout <= 1'b1;
                        st      <= ST_EXPIRE;
                    end else begin
                        // Losing candidates are remembered; anything else is dropped.
                        pend_1 <= cand_1 && !pick_1;
                        pend_R <= cand_R && !pick_R;
                        if (g_1) count_1 <= count_1 + 1'b1;
                        if (g_R) count_R <= count_R + 1'b1;
                        if (both) last_r <= pick_R;
                    end
                end
                ST_EXPIRE: begin
                    timeout <= enable;
                    if (!enable) st <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign state = st;

endmodule
